// File: rtl/risc32_pc_gen.sv
// rtl/risc32_pc_gen.sv - RISC32 fetch program-counter generator with boot delay and pending redirects
module risc32_pc_gen #(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int unsigned       INST_BYTES   = 4,
  parameter int unsigned       BOOT_CYCLES  = 1,
  parameter int unsigned       STALL_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STALL_W-1:0] stall,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o,
  output logic              pc_valid_o,
  output logic              redirect_pending_o,
  output logic              align_err_o
);

  // Low address bits that must be zero for an instruction-aligned target.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);
  localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(INST_BYTES);
  localparam logic [ADDR_W-1:0] RV_ALIGNED = RESET_VECTOR & ~ALIGN_MASK;
  localparam int unsigned       CNT_W      = $clog2(BOOT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  BOOT_LAST  = CNT_W'(BOOT_CYCLES - 1);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   boot_cnt_q, boot_cnt_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               pend_valid_q, pend_valid_d;
  logic               pend_flush_q, pend_flush_d;
  logic [ADDR_W-1:0]  pend_tgt_q, pend_tgt_d;
  logic               align_err_q, align_err_d;
  logic               take_redirect;
  logic [ADDR_W-1:0]  redirect_tgt;
  logic               fetch_stall;

  // Only the fetch stall bit matters here; the rest of the vector is deliberately ignored.
  logic unused_stall;
  assign unused_stall = ^stall;
  assign fetch_stall  = stall[0];

  // State, boot counter, PC and pending-redirect registers; rst forces everything back to boot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      boot_cnt_q   <= '0;
      pc_q         <= RV_ALIGNED;
      pend_valid_q <= 1'b0;
      pend_flush_q <= 1'b0;
      pend_tgt_q   <= '0;
      align_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      boot_cnt_q   <= boot_cnt_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_flush_q <= pend_flush_d;
      pend_tgt_q   <= pend_tgt_d;
      align_err_q  <= align_err_d;
    end
  end

  // Next-state logic: boot countdown, redirect priority when running, redirect capture while stalled.
  always_comb begin
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_flush_d  = pend_flush_q;
    pend_tgt_d    = pend_tgt_q;
    align_err_d   = 1'b0;
    take_redirect = 1'b0;
    redirect_tgt  = '0;

    case (state_q)
      ST_BOOT: begin
        boot_cnt_d   = boot_cnt_q + CNT_W'(1);
        pc_d         = RV_ALIGNED;
        pend_valid_d = 1'b0;
        pend_flush_d = 1'b0;
        pend_tgt_d   = '0;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!fetch_stall) begin
          pend_valid_d = 1'b0;
          pend_flush_d = 1'b0;
          if (flush_i) begin
            take_redirect = 1'b1;
            redirect_tgt  = flush_pc_i;
          end else if (pend_valid_q && pend_flush_q) begin
            take_redirect = 1'b1;
            redirect_tgt  = pend_tgt_q;
          end else if (branch_flag_i) begin
            take_redirect = 1'b1;
            redirect_tgt  = branch_target_i;
          end else if (pend_valid_q) begin
            take_redirect = 1'b1;
            redirect_tgt  = pend_tgt_q;
          end
          if (take_redirect) begin
            pc_d        = redirect_tgt & ~ALIGN_MASK;
            align_err_d = |(redirect_tgt & ALIGN_MASK);
          end else begin
            pc_d = pc_q + PC_INC;
          end
        end else begin
          // A flush always wins the pending slot; a branch never displaces a pending flush.
          if (flush_i) begin
            pend_valid_d = 1'b1;
            pend_flush_d = 1'b1;
            pend_tgt_d   = flush_pc_i;
          end else if (branch_flag_i && !(pend_valid_q && pend_flush_q)) begin
            pend_valid_d = 1'b1;
            pend_flush_d = 1'b0;
            pend_tgt_d   = branch_target_i;
          end
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign pc_o               = pc_q;
  assign ce_o               = (state_q == ST_RUN);
  assign pc_valid_o         = ce_o & ~fetch_stall;
  assign redirect_pending_o = pend_valid_q;
  assign align_err_o        = align_err_q;

endmodule

// File: doc/risc32_pc_gen.md
# risc32_pc_gen

Parametrised program-counter generator for the RISC32 fetch stage, replacing the fixed 32-bit PC. It adds a configurable reset vector, a boot delay before chip-enable, flush redirects with priority over branches, and a pending-redirect register so that no redirect is lost while fetch is stalled. It drives the instruction-memory address and chip enable, and feeds the IF/ID pipeline register.

## Interface
Parameters:
- ADDR_W, 32, PC and target width in bits.
- RESET_VECTOR, 0, PC value after reset, truncated to ADDR_W and aligned.
- INST_BYTES, 4, sequential increment; power of two, at least 1.
- BOOT_CYCLES, 1, clock edges after reset release during which ce_o stays low; at least 1.
- STALL_W, 6, width of the pipeline stall vector.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset: asynchronous, active-high.
- stall, in, STALL_W, pipeline stall vector; only stall[0] (fetch stall) is used.
- flush_i, in, 1, exception or ERET redirect request.
- flush_pc_i, in, ADDR_W, flush target.
- branch_flag_i, in, 1, taken branch or jump from ID.
- branch_target_i, in, ADDR_W, branch target.
- pc_o, out, ADDR_W, fetch address.
- ce_o, out, 1, instruction-memory chip enable.
- pc_valid_o, out, 1, fetch issued this cycle; equals ce_o & ~stall[0], combinational.
- redirect_pending_o, out, 1, a redirect is held in the pending register.
- align_err_o, out, 1, one-cycle pulse: the target just taken had nonzero low bits.

## Operation
- Define LSB = log2(INST_BYTES).
- All targets (flush, branch, pending) have bits [LSB-1:0] forced to zero before use. If the raw target had any of these bits set, align_err_o is 1 in the cycle after the redirect edge.
- States:
  - BOOT is entered on rst. A counter is cleared and ce_o=0. The counter increments each edge; when it reaches BOOT_CYCLES the state moves to RUN and ce_o becomes 1.
  - RUN continues until the next rst.
- While rst is asserted or the block is in BOOT:
  - pc_o holds RESET_VECTOR.
  - Pending state is held clear.
  - flush_i and branch_flag_i are ignored.
- In RUN with stall[0]=0, next pc_o is chosen by this priority:
  1. flush_i: take flush_pc_i.
  2. Pending flush: take the pending target.
  3. branch_flag_i: take branch_target_i.
  4. Pending branch: take the pending target.
  5. Otherwise pc_o + INST_BYTES, modulo 2^ADDR_W (wraps silently).
- The pending register clears on every RUN edge where stall[0]=0.
- In RUN with stall[0]=1:
  - pc_o holds.
  - A flush_i is captured as a pending flush and overwrites any pending branch.
  - A branch_flag_i is captured only if no flush is pending; a newer branch overwrites an older pending branch.
  - If flush_i and branch_flag_i arrive together, the flush is captured.
- redirect_pending_o = pending valid (registered).

## Timing
- Reset values: pc_o=RESET_VECTOR, ce_o=0, redirect_pending_o=0, align_err_o=0, boot counter=0, and therefore pc_valid_o=0.
- Boot sequence: after rst deasserts, ce_o rises on the BOOT_CYCLES-th rising edge. While ce_o=1 and pc_o is still RESET_VECTOR, that address is fetched once. The first increment happens on the next unstalled edge.
- Redirect latency is one edge: a flush or branch sampled at edge N sets pc_o to the target after edge N, provided stall[0]=0 at edge N.
- A redirect captured during a stall is applied at the first edge with stall[0]=0, and redirect_pending_o falls on that same edge.
- Asserting rst mid-operation forces all reset values asynchronously, discards any pending redirect, and restarts BOOT.

## Test plan
1. RESET_VECTOR=0xBFC00000, BOOT_CYCLES=3, stall=0: ce_o rises at the third edge after reset release; pc_o then reads 0xBFC00000, 0xBFC00004, 0xBFC00008 on successive cycles.
2. In RUN with pc_o=0x100, pulse branch_flag_i with target 0x200: the next pc_o is 0x200, then 0x204. With target 0x203 instead: pc_o becomes 0x200 and align_err_o pulses for one cycle.
3. Hold stall[0]=1 for 4 cycles while pulsing branch_flag_i (target 0x300) in cycle 1: pc_o holds and redirect_pending_o=1; one edge after stall releases, pc_o=0x300 and redirect_pending_o=0.
4. During a stall, pulse flush_i (target 0x180), then branch_flag_i (target 0x300) while still stalled: on release pc_o=0x180. Separately, assert flush_i and branch_flag_i in the same unstalled cycle: pc_o takes the flush target.
5. With ADDR_W=32 and pc_o=0xFFFFFFFC, no stall: the next pc_o is 0x00000000.
6. Assert rst asynchronously between edges while a redirect is pending: pc_o=RESET_VECTOR and ce_o=0 immediately, redirect_pending_o=0, and the full boot sequence repeats.
